// File: rtl/uart_frame_pkg.sv
// Shared constants and state encodings for the sensor-frame UART receiver.
// Frames are: ID byte, payload high byte, payload low byte, newline.
package uart_frame_pkg;

  localparam logic [7:0]  ID_LUX     = 8'hAA;
  localparam logic [7:0]  ID_HUM     = 8'hBB;
  localparam logic [7:0]  FRAME_TERM = 8'h0A;
  localparam logic [15:0] HUM_LIMIT  = 16'd100;

  typedef enum logic [1:0] {
    P_ID,
    P_HIGH,
    P_LOW,
    P_NL
  } parser_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic logic is_sensor_id(input logic [7:0] b);
    return (b == ID_LUX) || (b == ID_HUM);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// Byte-level UART receiver: 8N1, LSB first, mid-bit sampling.
// rx_valid pulses on a good stop bit, rx_ferr pulses on a stop bit of 0.
module uart_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            rx_valid_q, rx_ferr_q;

  // prev_q holds the previous synchronized level so a falling edge can be seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_BIT) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_BIT) begin
            cnt_q     <= '0;
            shift_q   <= {sync2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_BIT) begin
            cnt_q <= '0;
            if (sync2_q) begin
              rx_valid_q <= 1'b1;
              state_q    <= RX_IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
              state_q   <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (sync2_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data  = shift_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Sensor frame parser on top of uart_rx: accepts ID/high/low/newline frames,
// keeps per-sensor payloads and counts accepted and aborted frames.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_CLKS = 520800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_serial,
  output logic        frame_valid,
  output logic [7:0]  sensor_id,
  output logic [15:0] value,
  output logic [15:0] lux_value,
  output logic [15:0] humidity_value,
  output logic        frame_error,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]    rx_data;
  logic          rx_valid, rx_ferr;

  parser_state_e state_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    id_q, high_q, low_q;
  logic          frame_valid_q, frame_error_q;
  logic [7:0]    sensor_id_q, error_count_q;
  logic [15:0]   value_q, lux_q, hum_q, frame_count_q;

  logic [15:0]   payload;
  logic          timeout_hit, frame_ok, accept, abort;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // The inter-byte timer only runs while a frame is in progress
  always_comb begin
    timer_d     = '0;
    timeout_hit = 1'b0;
    if (state_q != P_ID && !rx_valid) begin
      timer_d     = timer_q + TW'(1);
      timeout_hit = (timer_q == TW'(TIMEOUT_CLKS - 1));
    end
  end

  always_comb begin
    payload  = {high_q, low_q};
    frame_ok = (rx_data == FRAME_TERM) && !((id_q == ID_HUM) && (payload > HUM_LIMIT));
    accept   = (state_q == P_NL) && rx_valid && frame_ok;
    abort    = (state_q != P_ID) &&
               (rx_ferr || timeout_hit || ((state_q == P_NL) && rx_valid && !frame_ok));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= P_ID;
      id_q          <= '0;
      high_q        <= '0;
      low_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      sensor_id_q   <= '0;
      value_q       <= '0;
      lux_q         <= '0;
      hum_q         <= '0;
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      if (abort) begin
        frame_error_q <= 1'b1;
        if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
        state_q <= P_ID;
      end else if (rx_valid) begin
        case (state_q)
          P_ID: begin
            if (is_sensor_id(rx_data)) begin
              id_q    <= rx_data;
              state_q <= P_HIGH;
            end
          end
          P_HIGH: begin
            high_q  <= rx_data;
            state_q <= P_LOW;
          end
          P_LOW: begin
            low_q   <= rx_data;
            state_q <= P_NL;
          end
          P_NL: begin
            if (accept) begin
              frame_valid_q <= 1'b1;
              sensor_id_q   <= id_q;
              value_q       <= payload;
              if (id_q == ID_LUX) lux_q <= payload;
              else                hum_q <= payload;
              frame_count_q <= frame_count_q + 16'd1;
            end
            state_q <= P_ID;
          end
          default: state_q <= P_ID;
        endcase
      end
    end
  end

  assign frame_valid    = frame_valid_q;
  assign frame_error    = frame_error_q;
  assign sensor_id      = sensor_id_q;
  assign value          = value_q;
  assign lux_value      = lux_q;
  assign humidity_value = hum_q;
  assign frame_count    = frame_count_q;
  assign error_count    = error_count_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a fast-baud instance for frame behaviour
// and a slow-baud instance where a 200-clock glitch is shorter than half a bit.
module tb_uart_frame_rx;

  localparam int CLKS         = 16;
  localparam int TIMEOUT      = 2000;
  localparam int SLOW_CLKS    = 512;
  localparam int SLOW_TIMEOUT = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line = 1'b1;
  logic        rx_slow = 1'b1;

  logic        frame_valid, frame_error;
  logic [7:0]  sensor_id, error_count;
  logic [15:0] value, lux_value, humidity_value, frame_count;

  logic        s_frame_valid, s_frame_error;
  logic [7:0]  s_sensor_id, s_error_count;
  logic [15:0] s_value, s_lux_value, s_humidity_value, s_frame_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int fv_pulses = 0, fe_pulses = 0, overlap = 0, s_fe_pulses = 0;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLKS_PER_BIT(CLKS), .TIMEOUT_CLKS(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_line),
    .frame_valid(frame_valid), .sensor_id(sensor_id), .value(value),
    .lux_value(lux_value), .humidity_value(humidity_value),
    .frame_error(frame_error), .frame_count(frame_count), .error_count(error_count)
  );

  uart_frame_rx #(.CLKS_PER_BIT(SLOW_CLKS), .TIMEOUT_CLKS(SLOW_TIMEOUT)) dut_slow (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_slow),
    .frame_valid(s_frame_valid), .sensor_id(s_sensor_id), .value(s_value),
    .lux_value(s_lux_value), .humidity_value(s_humidity_value),
    .frame_error(s_frame_error), .frame_count(s_frame_count), .error_count(s_error_count)
  );

  always @(negedge clk) begin
    if (frame_valid) fv_pulses++;
    if (frame_error) fe_pulses++;
    if (frame_valid && frame_error) overlap++;
    if (s_frame_error) s_fe_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic driveLine(input bit slow, input logic v, input int cycles);
    if (slow) rx_slow = v;
    else      rx_line = v;
    repeat (cycles) @(negedge clk);
  endtask

  // A stop bit of 0 is held low for three extra bit times before releasing the line
  task automatic applyStimulus(input logic [7:0] b, input bit slow = 1'b0,
                               input logic stop_bit = 1'b1, input bit rst_in_stop = 1'b0);
    int cpb;
    cpb = slow ? SLOW_CLKS : CLKS;
    driveLine(slow, 1'b0, cpb);
    for (int i = 0; i < 8; i++) driveLine(slow, b[i], cpb);
    if (rst_in_stop) begin
      driveLine(slow, stop_bit, cpb / 2);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      driveLine(slow, stop_bit, cpb / 2);
    end else begin
      driveLine(slow, stop_bit, cpb);
    end
    if (!stop_bit) driveLine(slow, 1'b0, 3 * cpb);
    driveLine(slow, 1'b1, cpb / 2);
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, input bit slow = 1'b0);
    applyStimulus(b0, slow);
    applyStimulus(b1, slow);
    applyStimulus(b2, slow);
    applyStimulus(b3, slow);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_error_count", error_count, 0);
    checkOutput("rst_frame_valid", frame_valid, 0);
    checkOutput("rst_value", value, 0);
    checkOutput("rst_sensor_id", sensor_id, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    sendFrame(8'hBB, 8'h00, 8'h2D, 8'h0A);
    checkOutput("hum45_fv_pulses", fv_pulses, 1);
    checkOutput("hum45_sensor_id", sensor_id, 8'hBB);
    checkOutput("hum45_value", value, 45);
    checkOutput("hum45_humidity", humidity_value, 45);
    checkOutput("hum45_frame_count", frame_count, 1);
    checkOutput("hum45_fe_pulses", fe_pulses, 0);

    applyStimulus(8'h55);
    sendFrame(8'hAA, 8'h01, 8'hF4, 8'h0A);
    checkOutput("hunt_lux", lux_value, 500);
    checkOutput("hunt_frame_count", frame_count, 2);
    checkOutput("hunt_fe_pulses", fe_pulses, 0);
    checkOutput("hunt_sensor_id", sensor_id, 8'hAA);

    sendFrame(8'hAA, 8'h00, 8'h10, 8'h0B);
    checkOutput("badterm_fe_pulses", fe_pulses, 1);
    checkOutput("badterm_error_count", error_count, 1);
    checkOutput("badterm_lux", lux_value, 500);
    checkOutput("badterm_value", value, 500);
    checkOutput("badterm_frame_count", frame_count, 2);
    sendFrame(8'hAA, 8'h00, 8'h20, 8'h0A);
    checkOutput("after_bad_lux", lux_value, 32);
    checkOutput("after_bad_frame_count", frame_count, 3);

    sendFrame(8'hBB, 8'h00, 8'h65, 8'h0A);
    checkOutput("hum101_error_count", error_count, 2);
    checkOutput("hum101_humidity", humidity_value, 45);
    checkOutput("hum101_frame_count", frame_count, 3);
    sendFrame(8'hBB, 8'h00, 8'h64, 8'h0A);
    checkOutput("hum100_humidity", humidity_value, 100);
    checkOutput("hum100_frame_count", frame_count, 4);

    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    repeat (TIMEOUT + 10) @(negedge clk);
    checkOutput("timeout_fe_pulses", fe_pulses, 3);
    checkOutput("timeout_error_count", error_count, 3);
    sendFrame(8'hAA, 8'h12, 8'h34, 8'h0A);
    checkOutput("post_timeout_value", value, 16'h1234);
    checkOutput("post_timeout_frame_count", frame_count, 5);

    applyStimulus(8'hAA);
    repeat (1700) @(negedge clk);
    applyStimulus(8'h00);
    repeat (1700) @(negedge clk);
    applyStimulus(8'h07);
    repeat (1700) @(negedge clk);
    applyStimulus(8'h0A);
    checkOutput("slow_gap_value", value, 7);
    checkOutput("slow_gap_frame_count", frame_count, 6);
    checkOutput("slow_gap_error_count", error_count, 3);

    applyStimulus(8'hAA);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("ferr_frame_fe_pulses", fe_pulses, 4);
    checkOutput("ferr_frame_error_count", error_count, 4);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("ferr_hunt_error_count", error_count, 4);
    sendFrame(8'hAA, 8'h00, 8'h03, 8'h0A);
    checkOutput("after_ferr_lux", lux_value, 3);
    checkOutput("after_ferr_frame_count", frame_count, 7);

    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    applyStimulus(8'h0A, 1'b0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("midrst_fv_pulses", fv_pulses, 7);
    checkOutput("midrst_fe_pulses", fe_pulses, 4);
    checkOutput("midrst_frame_count", frame_count, 0);
    checkOutput("midrst_error_count", error_count, 0);
    checkOutput("midrst_lux", lux_value, 0);
    checkOutput("midrst_humidity", humidity_value, 0);
    checkOutput("midrst_value", value, 0);
    sendFrame(8'hBB, 8'h00, 8'h0A, 8'h0A);
    checkOutput("post_rst_humidity", humidity_value, 10);
    checkOutput("post_rst_frame_count", frame_count, 1);

    applyStimulus(8'hAA, 1'b1);
    driveLine(1'b1, 1'b0, 200);
    driveLine(1'b1, 1'b1, 2 * SLOW_CLKS);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h0A, 1'b1);
    checkOutput("glitch_frame_count", s_frame_count, 1);
    checkOutput("glitch_value", s_value, 16'h1234);
    checkOutput("glitch_error_count", s_error_count, 0);
    checkOutput("glitch_fe_pulses", s_fe_pulses, 0);

    checkOutput("valid_error_overlap", overlap, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clocks per UART bit (9600 baud at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 520800, meaning maximum idle clocks between bytes inside one frame.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port rx_serial  input  1  UART line, idle high, asynchronous to clk.
REQ-006 SHALL have port frame_valid  output  1  one-cycle pulse when a complete, legal frame is accepted.
REQ-007 SHALL have port sensor_id  output  8  ID byte of the last accepted frame (0xAA lux, 0xBB humidity).
REQ-008 SHALL have port value  output  16  payload of the last accepted frame, high byte first on the wire.
REQ-009 SHALL have port lux_value  output  16  payload of the last accepted 0xAA frame.
REQ-010 SHALL have port humidity_value  output  16  payload of the last accepted 0xBB frame.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse when a frame is aborted.
REQ-012 SHALL have port frame_count  output  16  number of accepted frames.
REQ-013 SHALL have port error_count  output  8  number of aborted frames.

Function
REQ-014 SHALL pass rx_serial through a two-flop synchronizer before any use.
REQ-015 SHALL start byte reception on a synchronized falling edge and SHALL re-sample at CLKS_PER_BIT/2; a high level there is a false start and returns to idle with no byte.
REQ-016 SHALL sample 8 data bits LSB-first, then the stop bit, each CLKS_PER_BIT clocks after the previous sample.
REQ-017 SHALL emit an internal one-cycle byte strobe on a stop bit of 1, and SHALL flag a byte framing error with no strobe on a stop bit of 0.
REQ-018 Parser states SHALL be P_ID, P_HIGH, P_LOW and P_NL; reset state is P_ID.
REQ-019 In P_ID, on a byte equal to 0xAA or 0xBB: store the ID, go to P_HIGH.
REQ-020 In P_ID, on any other byte: discard it, stay in P_ID, and do not signal an error (hunting).
REQ-021 P_HIGH SHALL store bits [15:8] and go to P_LOW.
REQ-022 P_LOW SHALL store bits [7:0] and go to P_NL.
REQ-023 In P_NL, on byte 0x0A: pulse frame_valid, update sensor_id, value and the matching per-sensor register, increment frame_count, and return to P_ID.
REQ-024 In P_NL, on any byte other than 0x0A: abort.
REQ-025 An abort SHALL pulse frame_error, increment error_count, leave all data outputs unchanged, and return to P_ID.
REQ-026 A 0xBB frame with payload greater than 100 SHALL be aborted instead of accepted.
REQ-027 A byte framing error while the parser is outside P_ID SHALL abort; in P_ID it SHALL be ignored.
REQ-028 Outside P_ID, TIMEOUT_CLKS clocks without a byte strobe SHALL abort; the timer restarts on every strobe.
REQ-029 frame_valid SHALL rise exactly one clock after the strobe of the 0x0A byte; frame_valid and frame_error SHALL never assert together.
REQ-030 frame_count SHALL wrap from 0xFFFF to 0x0000.
REQ-031 error_count SHALL saturate at 0xFF.
REQ-032 If a stop bit of 0 is followed by a low line, the receiver SHALL wait for the line to return high before hunting for a new start bit.

Reset
REQ-033 While rst_n=0 at a clk edge, all outputs SHALL go to 0, the parser to P_ID, the receiver to idle, and the synchronizer flops to 1.
REQ-034 Reset asserted mid-byte or mid-frame SHALL discard the partial data, with no frame_valid or frame_error pulse.

Structure
REQ-035 ID constants (0xAA, 0xBB), the terminator 0x0A, the humidity limit 100 and the parser state encodings SHALL live in a shared package, uart_frame_pkg.
REQ-036 Byte-level reception (synchronizer, bit timing, stop check) SHALL be one sub-module named uart_rx, with ports clk, rst_n, rx_serial, rx_data[7:0], rx_valid and rx_ferr; the parser SHALL be in uart_frame_rx.

Verification
REQ-037 Send 0xBB 0x00 0x2D 0x0A -> one frame_valid; sensor_id=0xBB, value=45, humidity_value=45, frame_count=1.
REQ-038 Send 0x55 0xAA 0x01 0xF4 0x0A -> 0x55 silently dropped; lux_value=500, no frame_error.
REQ-039 Send 0xAA 0x00 0x10 0x0B -> frame_error pulse, error_count=1, lux_value unchanged; the next good frame is accepted.
REQ-040 Send 0xBB 0x00 0x65 0x0A -> aborted (payload 101); humidity_value keeps its previous value.
REQ-041 Send 0xAA 0x00, then idle for TIMEOUT_CLKS+10 clocks -> exactly one frame_error; then 0xAA 0x12 0x34 0x0A -> value=0x1234.
REQ-042 Assert rst_n=0 during the stop bit of 0x0A -> no frame_valid, all counters 0; a 200-clock low glitch on rx_serial -> no byte.
